shift_reg_en: RTL and testbench
===============================

# shift_reg_en

Parametrised, enable-gated multi-stage register pipeline: WIDTH-bit data moves through DEPTH stages under a clock enable. Adds parallel load, synchronous clear, per-stage valid tracking and fill status. Serves as the general delay-line/staging element in datapath labs where a single-bit enabled flip-flop no longer suffices.

## Interface
- WIDTH, 8, data width of each stage (≥1)
- DEPTH, 4, number of stages (≥1); d-to-q latency in shift cycles
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  clock enable; 0 holds all state regardless of op
- op  input  2  operation: 00 hold, 01 shift, 10 parallel load, 11 clear
- d  input  WIDTH  serial data entering stage 0 on shift
- d_par  input  WIDTH*DEPTH  parallel load data; slice [WIDTH*i +: WIDTH] → stage i
- q  output  WIDTH  stage DEPTH-1 contents
- q_all  output  WIDTH*DEPTH  all stages, same slicing as d_par
- q_valid  output  1  valid bit of stage DEPTH-1
- fill_cnt  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH
- full  output  1  fill_cnt == DEPTH

## Operation
- Priority per edge: reset > en=0 (hold) > op.
- reset=1: all stages 0, all valid bits 0, fill_cnt 0.
- en=0: no state change; op, d and d_par ignored.
- op=00 hold: no change.
- op=01 shift: stage0 ← d, stage i ← stage i-1; valid0 ← 1, valid i ← valid i-1; stage DEPTH-1 data is discarded. fill_cnt increments, saturating at DEPTH.
- op=10 load: all stages ← d_par slices; all valid 1; fill_cnt ← DEPTH.
- op=11 clear: identical effect to reset.
- fill_cnt equals popcount of the valid vector at all times; once filled by shifts alone, valid vector is contiguous from stage 0.
- DEPTH=1: single stage; shift writes d directly to q.

## Timing
- All outputs registered; change only on rising clk edge, no combinational path from inputs to outputs.
- Reset value of every output: 0 (q, q_all, q_valid, fill_cnt, full).
- Latency: value on d with shift accepted at edge N appears on q after edge N+DEPTH-1 (DEPTH shift edges counting N), provided en=1 and op=01 on each.
- Idle cycles (en=0 or op=00) between shifts stall the pipeline without loss; latency counts shift edges, not clock edges.
- Shift while full: data/valid of last stage drop, fill_cnt stays DEPTH, full stays 1.
- Reset asserted mid-sequence: takes effect at that edge regardless of en/op; releasing reset resumes normal operation the next edge.

## Structure
- Shared package: op encoding constants (OP_HOLD, OP_SHIFT, OP_LOAD, OP_CLR).
- One sub-module, dff_en_w: WIDTH-parameterised enabled register with sync reset, instantiated DEPTH times via generate; stage-select muxing and valid/fill_cnt logic live in the top level.

## Test plan
- Reset: reset=1 for one edge with en=1, op=01, d=0xFF → q=0, q_all=0, q_valid=0, fill_cnt=0, full=0.
- Fill (WIDTH=8, DEPTH=4): shift 0x11,0x22,0x33,0x44 → q_all=0x11223344, q=0x11, fill_cnt=4, full=1; shift 0x55 → q=0x22, fill_cnt=4.
- Enable gating: after fill, en=0, op=01, d toggling 0x00/0xFF for 3 edges → q_all unchanged 0x22334455; en=1 resumes shifting next edge.
- Load/clear: en=1, op=10, d_par=0xA1B2C3D4 → q=0xA1, q_all=0xA1B2C3D4, fill_cnt=4; next edge op=11 → all outputs 0.
- Reset priority: mid-fill (fill_cnt=2), reset=1 with en=1, op=10 → next edge all outputs 0, no load.
- DEPTH=1: shift 0x5A → q=0x5A, q_valid=1, full=1 after one edge; shift 0xC3 → q=0xC3.

Source files
------------

// File: rtl/shift_reg_en_pkg.sv
// rtl/shift_reg_en_pkg.sv - op encodings shared by the staging pipeline
package shift_reg_en_pkg;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

endpackage

// File: rtl/dff_en_w.sv
// rtl/dff_en_w.sv - WIDTH-bit enabled register with synchronous reset
module dff_en_w #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_reg_en.sv
// rtl/shift_reg_en.sv - enable-gated DEPTH-stage pipeline with load, clear and fill tracking
module shift_reg_en
  import shift_reg_en_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           d,
  input  logic [WIDTH*DEPTH-1:0]     d_par,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH*DEPTH-1:0]     q_all,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic             stage_rst;
  logic             stage_en;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_sh;

  // clear shares the reset path so both behave identically
  assign stage_rst = reset | (en & (op == OP_CLR));
  assign stage_en  = en & ((op == OP_SHIFT) | (op == OP_LOAD));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] din;

    if (gi == 0) begin : g_head
      assign shift_in = d;
    end else begin : g_body
      assign shift_in = q_all[WIDTH*(gi-1) +: WIDTH];
    end

    assign din = (op == OP_LOAD) ? d_par[WIDTH*gi +: WIDTH] : shift_in;

    dff_en_w #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (stage_rst),
      .en  (stage_en),
      .d   (din),
      .q   (q_all[WIDTH*gi +: WIDTH])
    );
  end

  always_comb begin
    valid_sh    = valid << 1;
    valid_sh[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (stage_rst) begin
      valid    <= '0;
      fill_cnt <= '0;
    end else if (en) begin
      case (op)
        OP_SHIFT: begin
          valid <= valid_sh;
          if (fill_cnt != DEPTH_C) begin
            fill_cnt <= fill_cnt + CW'(1);
          end
        end
        OP_LOAD: begin
          valid    <= '1;
          fill_cnt <= DEPTH_C;
        end
        default: begin
        end
      endcase
    end
  end

  assign q       = q_all[WIDTH*(DEPTH-1) +: WIDTH];
  assign q_valid = valid[DEPTH-1];
  assign full    = (fill_cnt == DEPTH_C);

endmodule

// File: tb/tb_shift_reg_en.sv
// tb/tb_shift_reg_en.sv - scoreboard bench for shift_reg_en at DEPTH=4 and DEPTH=1
module tb_shift_reg_en;

  typedef struct {
    logic [31:0] qall;
    logic [7:0]  q;
    logic        qv;
    int          fill;
    logic        full;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  d = 8'h00;
  logic [31:0] d_par = 32'h0;

  logic [7:0]  q4, q1;
  logic [31:0] qall4;
  logic [7:0]  qall1;
  logic        qv4, qv1, full4, full1;
  logic [2:0]  fill4;
  logic [0:0]  fill1;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb4[$];
  exp_t sb1[$];

  logic [7:0] m [2][4];
  int         mfill [2];
  int         mdepth [2] = '{4, 1};

  always #5 clk = ~clk;

  shift_reg_en #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .op(op), .d(d), .d_par(d_par),
    .q(q4), .q_all(qall4), .q_valid(qv4), .fill_cnt(fill4), .full(full4)
  );

  shift_reg_en #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .op(op), .d(d), .d_par(d_par[7:0]),
    .q(q1), .q_all(qall1), .q_valid(qv1), .fill_cnt(fill1), .full(full1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: stage 0 is the newest entry; the valid run always starts at stage 0.
  task automatic model_step(input int k, input logic r, input logic e, input logic [1:0] o,
                            input logic [7:0] dd, input logic [31:0] dp);
    int dep;
    dep = mdepth[k];
    if (r || (e && o == 2'b11)) begin
      for (int i = 0; i < 4; i++) m[k][i] = 8'h00;
      mfill[k] = 0;
    end else if (e && o == 2'b01) begin
      for (int i = dep - 1; i > 0; i--) m[k][i] = m[k][i-1];
      m[k][0] = dd;
      mfill[k] = (mfill[k] + 1 > dep) ? dep : mfill[k] + 1;
    end else if (e && o == 2'b10) begin
      for (int i = 0; i < dep; i++) m[k][i] = dp[8*i +: 8];
      mfill[k] = dep;
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t x;
    int dep;
    dep = mdepth[k];
    x.qall = 32'h0;
    for (int i = 0; i < dep; i++) x.qall[8*i +: 8] = m[k][i];
    x.q    = m[k][dep-1];
    x.fill = mfill[k];
    x.full = (mfill[k] == dep);
    x.qv   = (mfill[k] == dep);
    return x;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic [1:0] o,
                     input logic [7:0] dd, input logic [31:0] dp);
    @(negedge clk);
    reset = r; en = e; op = o; d = dd; d_par = dp;
    model_step(0, r, e, o, dd, dp);
    model_step(1, r, e, o, dd, dp);
    sb4.push_back(model_out(0));
    sb1.push_back(model_out(1));
  endtask

  initial begin : mon4
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb4.size() > 0) begin
        x = sb4.pop_front();
        chk("d4_q_all",    qall4,        x.qall);
        chk("d4_q",        {24'h0, q4},  {24'h0, x.q});
        chk("d4_q_valid",  {31'h0, qv4}, {31'h0, x.qv});
        chk("d4_fill_cnt", {29'h0, fill4}, 32'(x.fill));
        chk("d4_full",     {31'h0, full4}, {31'h0, x.full});
      end
    end
  end

  initial begin : mon1
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb1.size() > 0) begin
        x = sb1.pop_front();
        chk("d1_q_all",    {24'h0, qall1}, x.qall);
        chk("d1_q",        {24'h0, q1},    {24'h0, x.q});
        chk("d1_q_valid",  {31'h0, qv1},   {31'h0, x.qv});
        chk("d1_fill_cnt", {31'h0, fill1}, 32'(x.fill));
        chk("d1_full",     {31'h0, full1}, {31'h0, x.full});
      end
    end
  end

  initial begin : stim
    logic [1:0] o;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m[k][i] = 8'h00;
      mfill[k] = 0;
    end

    cyc(1'b1, 1'b1, 2'b01, 8'hFF, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 8'h11, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 8'h22, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 8'h33, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 8'h44, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 8'h55, 32'h0);
    cyc(1'b0, 1'b0, 2'b01, 8'h00, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b0, 2'b01, 8'hFF, 32'h0);
    cyc(1'b0, 1'b0, 2'b11, 8'h00, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 8'h66, 32'h0);
    cyc(1'b0, 1'b1, 2'b00, 8'h77, 32'h0);
    cyc(1'b0, 1'b1, 2'b10, 8'h00, 32'hA1B2_C3D4);
    cyc(1'b0, 1'b1, 2'b11, 8'h00, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 8'h5A, 32'h0);
    cyc(1'b0, 1'b1, 2'b01, 8'hC3, 32'h0);
    cyc(1'b1, 1'b1, 2'b10, 8'h00, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b1, 2'b01, 8'h9E, 32'h0);

    for (int n = 0; n < 400; n++) begin
      o = 2'($urandom_range(0, 3));
      if (o == 2'b11 && $urandom_range(0, 3) != 0) o = 2'b01;
      cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 4) != 0), o,
          8'($urandom), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("sb4_drained", 32'(sb4.size()), 32'h0);
    chk("sb1_drained", 32'(sb1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
